// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and constants for the L2 cache controller
package l2_cache_pkg;
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} l2_state_t;
    typedef enum logic {DSEL_PMEM = 1'b0, DSEL_CPU = 1'b1} data_sel_t;
    typedef enum logic {PADDR_CPU = 1'b0, PADDR_WB = 1'b1} paddr_sel_t;
    localparam int NUM_WAYS = 2;
endpackage

// File: rtl/l2_sat_counter.sv
// l2_sat_counter: counter that sticks at its maximum value instead of wrapping
module l2_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    // clear on reset, count up until all ones
    always_ff @(posedge clk)
        if (rst) count <= '0;
        else if (inc && count != '1) count <= count + WIDTH'(1);
endmodule

// File: rtl/l2_cache_control.sv
// l2_cache_control: write-back write-allocate 2-way L2 control FSM with hit/miss counters
module l2_cache_control
    import l2_cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic [NUM_WAYS-1:0] dirty,
    input  logic                lru,
    output logic [NUM_WAYS-1:0] load_tag,
    output logic [NUM_WAYS-1:0] load_valid,
    output logic [NUM_WAYS-1:0] load_dirty,
    output logic                dirty_in,
    output logic                load_lru,
    output logic                lru_in,
    output logic [NUM_WAYS-1:0] load_data,
    output logic                data_sel,
    output logic                paddr_sel,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);
    l2_state_t state, nxt;
    logic w, hit_inc, miss_inc;
    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : nxt;
    // next state and array/datapath controls; reset suppresses every load
    always_comb begin
        nxt = state;
        mem_resp = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        load_tag = '0;
        load_valid = '0;
        load_dirty = '0;
        dirty_in = 1'b0;
        load_lru = 1'b0;
        lru_in = 1'b0;
        load_data = '0;
        data_sel = DSEL_PMEM;
        paddr_sel = PADDR_CPU;
        hit_inc = 1'b0;
        miss_inc = 1'b0;
        w = ~hit[0];
        case (state)
            IDLE: nxt = (mem_read || mem_write) ? COMPARE : IDLE;
            COMPARE:
                if (|hit) begin
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in = ~w;
                    hit_inc = 1'b1;
                    if (mem_write) begin
                        load_data[w] = 1'b1;
                        data_sel = DSEL_CPU;
                        load_dirty[w] = 1'b1;
                        dirty_in = 1'b1;
                    end
                    nxt = IDLE;
                end else begin
                    miss_inc = 1'b1;
                    nxt = dirty[lru] ? WRITEBACK : ALLOCATE;
                end
            WRITEBACK: begin
                pmem_write = 1'b1;
                paddr_sel = PADDR_WB;
                if (pmem_resp) begin
                    load_dirty[lru] = 1'b1;
                    nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data[lru] = 1'b1;
                    load_tag[lru] = 1'b1;
                    load_valid[lru] = 1'b1;
                    load_dirty[lru] = 1'b1;
                    nxt = COMPARE;
                end
            end
            default: nxt = IDLE;
        endcase
        if (rst) begin
            mem_resp = 1'b0;
            load_tag = '0;
            load_valid = '0;
            load_dirty = '0;
            load_lru = 1'b0;
            load_data = '0;
            hit_inc = 1'b0;
            miss_inc = 1'b0;
        end
    end
    l2_sat_counter #(.WIDTH(CNT_W)) u_hit (.clk(clk), .rst(rst), .inc(hit_inc), .count(hit_count));
    l2_sat_counter #(.WIDTH(CNT_W)) u_miss (.clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count));
endmodule
